ap_ctrl_sequencer: RTL and testbench
====================================

# ap_ctrl_sequencer

Synthesizable stimulus and transaction-tracking stage that drives the `ap_ctrl_hs` block-level handshake of the `hand_num_nn` accelerator. It issues a programmed number of `ap_start` transactions and tracks outstanding calls in a timestamp FIFO. It reports per-transaction latency statistics and raises `finish` when the last `ap_done` is observed. It sits directly upstream of the dataflow monitor, which samples the same `ap_start`/`ap_ready`/`ap_done` wires and terminates on this block's `finish`.

## Interface
- `NUM_TRANS`, 10: number of transactions to issue (0 allowed).
- `DEPTH`, 4: maximum outstanding transactions; must be a power of two, ≥1.
- `CNT_W`, 32: width of all counters and latency outputs.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `enable`  in  1  permits issuing new starts.
- `ap_start`  out  1  handshake request to the DUT.
- `ap_ready`  in  1  DUT accepted the current start.
- `ap_done`  in  1  DUT completed the oldest outstanding transaction.
- `trans_started`  out  CNT_W  count of accepted starts.
- `trans_done`  out  CNT_W  count of valid completions.
- `last_latency`  out  CNT_W  latency of the most recent completion.
- `min_latency`  out  CNT_W  minimum latency seen.
- `max_latency`  out  CNT_W  maximum latency seen.
- `finish`  out  1  all NUM_TRANS transactions completed; sticky.
- `error`  out  1  `ap_done` with nothing outstanding; sticky.

## Operation
- Free-running cycle counter `now` (CNT_W, wraps) runs in every state except reset.
- **Acceptance**: a start is accepted in any cycle with `ap_start && ap_ready`.
  - Push `now` into the FIFO.
  - Increment `trans_started`.
- **Completion**: `ap_done` pops the oldest timestamp.
  - Latency = `now − timestamp`, computed modulo 2^CNT_W.
  - Updates `last_latency`, `min_latency` and `max_latency`; increments `trans_done`.
- **Simultaneous acceptance and `ap_done`**:
  - FIFO non-empty: push and pop in the same cycle; occupancy is unchanged.
  - FIFO empty: bypass the FIFO, latency 0, valid completion.
- **Spurious done**: `ap_done` with the FIFO empty and no same-cycle acceptance sets `error`. The done is ignored; counters and statistics are unchanged.
- **States**:
  - IDLE: `ap_start`=0. Go to RUN when `enable`=1, or straight to FINISH if NUM_TRANS=0.
  - RUN: `ap_start` is registered high when all hold: `enable`, `trans_started`<NUM_TRANS, occupancy<DEPTH. Each condition is evaluated on next-state values, so `ap_start` falls in the cycle after the acceptance that reaches the limit. Go to DRAIN when `trans_started` reaches NUM_TRANS.
  - DRAIN: `ap_start`=0. Go to FINISH when `trans_done` reaches NUM_TRANS.
  - FINISH: `finish`=1 and `ap_start`=0. Exit only by reset.
- **`enable` low in RUN**: no new starts (`ap_start` drops next cycle). Completions are still tracked. Issuing resumes when `enable` returns high.
- `ap_ready` without `ap_start`, and `ap_done` in IDLE, are not acceptances or completions. `ap_done` in IDLE sets `error`.

## Timing
- Reset values:
  - `ap_start`, `finish`, `error`: 0.
  - `trans_started`, `trans_done`, `last_latency`, `max_latency`: 0.
  - `min_latency`: all ones.
  - FIFO empty, state IDLE, `now`=0.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously); in-flight transactions are discarded.
- `ap_start` rises 1 cycle after `enable` is sampled high in IDLE.
- `ap_start` stays high across back-to-back acceptances while permitted, so one acceptance per cycle is possible.
- Counters and statistics update on the clock edge that samples the event and are visible the next cycle.
- `finish` rises 2 cycles after the final `ap_done` is sampled: 1 cycle for the `trans_done` update, then the state transition. It then stays high.

## Test plan
- **Sequential calls**: NUM_TRANS=3, DEPTH=4. DUT model asserts `ap_ready` with each start and `ap_done` 5 cycles after acceptance, accepting a new start only after done.
  -> `trans_started`=`trans_done`=3, `last_latency`=`min_latency`=`max_latency`=5, `finish`=1, `error`=0.
- **Pipelined, FIFO full**: NUM_TRANS=8, DEPTH=4. `ap_ready` held high, done latency 7.
  -> `ap_start` drops after 4 back-to-back acceptances and re-rises after the first done; latencies all 7; `finish` 2 cycles after the 8th done.
- **Bypass**: NUM_TRANS=1, FIFO empty, `ap_ready` and `ap_done` asserted in the same cycle as `ap_start`.
  -> `last_latency`=0, `min_latency`=0, `trans_done`=1, `finish`=1.
- **Spurious done**: pulse `ap_done` in IDLE, then run NUM_TRANS=2 normally.
  -> `error`=1 sticky; `trans_done` ends at 2 (not 3); `finish`=1.
- **Enable gap and reset**: `enable` low for 10 cycles mid-RUN.
  -> no acceptances during the gap; outstanding completions still counted.
  - Then assert `reset` mid-DRAIN -> all outputs return to reset values in the same cycle.
  - `min_latency` reads 0xFFFFFFFF (CNT_W=32).
- **Zero transactions**: NUM_TRANS=0, `enable`=1.
  -> `ap_start` never asserts; `finish`=1 one cycle after `enable` is sampled.

Source files
------------

// File: rtl/ap_ctrl_sequencer.sv
// Drives the ap_ctrl_hs start/ready/done handshake for a programmed number of calls,
// timestamps each accepted start in a small FIFO and reports completion latency statistics.
module ap_ctrl_sequencer #(
  parameter int NUM_TRANS = 10,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic [CNT_W-1:0] trans_started,
  output logic [CNT_W-1:0] trans_done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             finish,
  output logic             error,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] NUM_T    = CNT_W'(NUM_TRANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // Handshake: a start is accepted in any cycle where ap_start and ap_ready are both
  // high; ap_done retires the oldest accepted start (or the same-cycle one when empty).

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] now_q;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ap_start_q, ap_start_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             finish_q, finish_d;
  logic             error_q, error_d;

  logic             accept;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             spurious;
  logic             complete;
  logic [CNT_W-1:0] latency;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    accept     = ap_start_q && ap_ready;
    fifo_empty = (occ_q == '0);
    pop        = ap_done && !fifo_empty;
    bypass     = ap_done && fifo_empty && accept;
    spurious   = ap_done && fifo_empty && !accept;
    push       = accept && !bypass;
    complete   = pop || bypass;
    // Wrapping subtraction keeps the latency correct across a now_q rollover.
    latency    = bypass ? '0 : (now_q - mem_q[rd_ptr_q]);
  end

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d     = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    started_d = accept ? started_q + CNT_ONE : started_q;
  end

  always_comb begin
    done_d  = done_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    error_d = error_q | spurious;
    if (complete) begin
      done_d = done_q + CNT_ONE;
      last_d = latency;
      if (latency < min_q) min_d = latency;
      if (latency > max_q) max_d = latency;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = (NUM_T == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (started_d == NUM_T) state_d = S_DRAIN;
      S_DRAIN:  if (done_q == NUM_T) state_d = S_FINISH;
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
    // Next-state values let ap_start fall right after the acceptance that hits a limit.
    ap_start_d = (state_d == S_RUN) && enable && (started_d < NUM_T) && (occ_d < DEPTH_C);
    finish_d   = (state_d == S_FINISH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      now_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ap_start_q <= 1'b0;
      started_q  <= '0;
      done_q     <= '0;
      last_q     <= '0;
      min_q      <= '1;
      max_q      <= '0;
      finish_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      now_q      <= now_q + CNT_ONE;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ap_start_q <= ap_start_d;
      started_q  <= started_d;
      done_q     <= done_d;
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
      finish_q   <= finish_d;
      error_q    <= error_d;
    end
  end

  // Timestamp storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= now_q;
  end

  assign ap_start      = ap_start_q;
  assign trans_started = started_q;
  assign trans_done    = done_q;
  assign last_latency  = last_q;
  assign min_latency   = min_q;
  assign max_latency   = max_q;
  assign finish        = finish_q;
  assign error         = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench: five sequencer instances with different transaction counts, each
// exercised by its own scenario task against hand-computed cycle-accurate expectations.
module tb_ap_ctrl_sequencer;

  localparam int N_INST = 5;
  localparam int SEQ    = 0;
  localparam int PIPE   = 1;
  localparam int BYP    = 2;
  localparam int SPUR   = 3;
  localparam int ZERO   = 4;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N_INST-1:0] en;
  logic [N_INST-1:0] rdy;
  logic [N_INST-1:0] dn;
  logic        st  [N_INST];
  logic [31:0] ts  [N_INST];
  logic [31:0] td  [N_INST];
  logic [31:0] ll  [N_INST];
  logic [31:0] mn  [N_INST];
  logic [31:0] mx  [N_INST];
  logic        fin [N_INST];
  logic        err [N_INST];
  logic [1:0]  dbg [N_INST];

  int nchecks = 0;
  int nerrs   = 0;

  logic st_hist [64];
  int   m_acc;
  int   m_gap_acc;
  int   m_fin_c;
  logic [31:0] m_td_gap_end;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    ap_ctrl_sequencer #(
      .NUM_TRANS((g == SEQ) ? 3 : (g == PIPE) ? 8 : (g == BYP) ? 1 : (g == SPUR) ? 2 : 0),
      .DEPTH(4),
      .CNT_W(32)
    ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (en[g]),
      .ap_start     (st[g]),
      .ap_ready     (rdy[g]),
      .ap_done      (dn[g]),
      .trans_started(ts[g]),
      .trans_done   (td[g]),
      .last_latency (ll[g]),
      .min_latency  (mn[g]),
      .max_latency  (mx[g]),
      .finish       (fin[g]),
      .error        (err[g]),
      .dbg_state    (dbg[g])
    );
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    en    = '0;
    rdy   = '0;
    dn    = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Responder for one instance: ready while fewer than cap calls are in flight, done
  // exactly lat cycles after each acceptance; enable is low for gap_l cycles from gap_s.
  task automatic run_model(input int i, input int lat, input int cap, input int ncyc,
                           input int gap_s, input int gap_l);
    int due_q[$];
    m_acc        = 0;
    m_gap_acc    = 0;
    m_fin_c      = -1;
    m_td_gap_end = '0;
    for (int c = 0; c < ncyc; c++) begin
      en[i]  = !((c >= gap_s) && (c < gap_s + gap_l));
      rdy[i] = (due_q.size() < cap);
      dn[i]  = 1'b0;
      if (due_q.size() > 0 && due_q[0] == c) begin
        dn[i] = 1'b1;
        void'(due_q.pop_front());
      end
      if (c < 64) st_hist[c] = st[i];
      if (fin[i] && m_fin_c < 0) m_fin_c = c;
      if (c == gap_s + gap_l) m_td_gap_end = td[i];
      if (st[i] && rdy[i]) begin
        due_q.push_back(c + lat);
        m_acc++;
        if (c > gap_s && c <= gap_s + gap_l) m_gap_acc++;
      end
      tick();
    end
    en[i]  = 1'b0;
    rdy[i] = 1'b0;
    dn[i]  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++; if (st[PIPE] !== 1'b0) begin nerrs++; $display("FAIL reset_ap_start: got %b exp 0", st[PIPE]); end
    nchecks++; if (ts[PIPE] !== 32'd0) begin nerrs++; $display("FAIL reset_started: got %0d exp 0", ts[PIPE]); end
    nchecks++; if (td[PIPE] !== 32'd0) begin nerrs++; $display("FAIL reset_done: got %0d exp 0", td[PIPE]); end
    nchecks++; if (ll[PIPE] !== 32'd0) begin nerrs++; $display("FAIL reset_last: got %0d exp 0", ll[PIPE]); end
    nchecks++; if (mn[PIPE] !== ALL_ONES) begin nerrs++; $display("FAIL reset_min: got %0h exp ffffffff", mn[PIPE]); end
    nchecks++; if (mx[PIPE] !== 32'd0) begin nerrs++; $display("FAIL reset_max: got %0d exp 0", mx[PIPE]); end
    nchecks++; if (fin[PIPE] !== 1'b0) begin nerrs++; $display("FAIL reset_finish: got %b exp 0", fin[PIPE]); end
    nchecks++; if (err[PIPE] !== 1'b0) begin nerrs++; $display("FAIL reset_error: got %b exp 0", err[PIPE]); end
  endtask

  task automatic test_sequential();
    do_reset();
    run_model(SEQ, 5, 1, 25, 0, 0);
    nchecks++; if (ts[SEQ] !== 32'd3) begin nerrs++; $display("FAIL seq_started: got %0d exp 3", ts[SEQ]); end
    nchecks++; if (td[SEQ] !== 32'd3) begin nerrs++; $display("FAIL seq_done: got %0d exp 3", td[SEQ]); end
    nchecks++; if (ll[SEQ] !== 32'd5) begin nerrs++; $display("FAIL seq_last: got %0d exp 5", ll[SEQ]); end
    nchecks++; if (mn[SEQ] !== 32'd5) begin nerrs++; $display("FAIL seq_min: got %0d exp 5", mn[SEQ]); end
    nchecks++; if (mx[SEQ] !== 32'd5) begin nerrs++; $display("FAIL seq_max: got %0d exp 5", mx[SEQ]); end
    nchecks++; if (fin[SEQ] !== 1'b1) begin nerrs++; $display("FAIL seq_finish: got %b exp 1", fin[SEQ]); end
    nchecks++; if (err[SEQ] !== 1'b0) begin nerrs++; $display("FAIL seq_error: got %b exp 0", err[SEQ]); end
    nchecks++; if (m_fin_c != 20) begin nerrs++; $display("FAIL seq_finish_cycle: got %0d exp 20", m_fin_c); end
    nchecks++; if (m_acc != 3) begin nerrs++; $display("FAIL seq_accept_count: got %0d exp 3", m_acc); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_st;
    exp_st = 14'b01111000011110;
    do_reset();
    run_model(PIPE, 7, 99, 30, 0, 0);
    for (int c = 0; c < 14; c++) begin
      nchecks++;
      if (st_hist[c] !== exp_st[c]) begin nerrs++; $display("FAIL pipe_ap_start_c%0d: got %b exp %b", c, st_hist[c], exp_st[c]); end
    end
    nchecks++; if (ts[PIPE] !== 32'd8) begin nerrs++; $display("FAIL pipe_started: got %0d exp 8", ts[PIPE]); end
    nchecks++; if (td[PIPE] !== 32'd8) begin nerrs++; $display("FAIL pipe_done: got %0d exp 8", td[PIPE]); end
    nchecks++; if (ll[PIPE] !== 32'd7) begin nerrs++; $display("FAIL pipe_last: got %0d exp 7", ll[PIPE]); end
    nchecks++; if (mn[PIPE] !== 32'd7) begin nerrs++; $display("FAIL pipe_min: got %0d exp 7", mn[PIPE]); end
    nchecks++; if (mx[PIPE] !== 32'd7) begin nerrs++; $display("FAIL pipe_max: got %0d exp 7", mx[PIPE]); end
    nchecks++; if (fin[PIPE] !== 1'b1) begin nerrs++; $display("FAIL pipe_finish: got %b exp 1", fin[PIPE]); end
    nchecks++; if (err[PIPE] !== 1'b0) begin nerrs++; $display("FAIL pipe_error: got %b exp 0", err[PIPE]); end
    nchecks++; if (m_fin_c != 21) begin nerrs++; $display("FAIL pipe_finish_cycle: got %0d exp 21", m_fin_c); end
  endtask

  task automatic test_bypass();
    do_reset();
    en[BYP] = 1'b1;
    tick();
    nchecks++; if (st[BYP] !== 1'b1) begin nerrs++; $display("FAIL byp_ap_start_rise: got %b exp 1", st[BYP]); end
    rdy[BYP] = 1'b1;
    dn[BYP]  = 1'b1;
    tick();
    rdy[BYP] = 1'b0;
    dn[BYP]  = 1'b0;
    nchecks++; if (ts[BYP] !== 32'd1) begin nerrs++; $display("FAIL byp_started: got %0d exp 1", ts[BYP]); end
    nchecks++; if (td[BYP] !== 32'd1) begin nerrs++; $display("FAIL byp_done: got %0d exp 1", td[BYP]); end
    nchecks++; if (ll[BYP] !== 32'd0) begin nerrs++; $display("FAIL byp_last: got %0d exp 0", ll[BYP]); end
    nchecks++; if (mn[BYP] !== 32'd0) begin nerrs++; $display("FAIL byp_min: got %0d exp 0", mn[BYP]); end
    nchecks++; if (mx[BYP] !== 32'd0) begin nerrs++; $display("FAIL byp_max: got %0d exp 0", mx[BYP]); end
    nchecks++; if (st[BYP] !== 1'b0) begin nerrs++; $display("FAIL byp_ap_start_fall: got %b exp 0", st[BYP]); end
    nchecks++; if (fin[BYP] !== 1'b0) begin nerrs++; $display("FAIL byp_finish_early: got %b exp 0", fin[BYP]); end
    nchecks++; if (err[BYP] !== 1'b0) begin nerrs++; $display("FAIL byp_error: got %b exp 0", err[BYP]); end
    tick();
    nchecks++; if (fin[BYP] !== 1'b1) begin nerrs++; $display("FAIL byp_finish: got %b exp 1", fin[BYP]); end
    en[BYP] = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    dn[SPUR] = 1'b1;
    tick();
    dn[SPUR] = 1'b0;
    nchecks++; if (err[SPUR] !== 1'b1) begin nerrs++; $display("FAIL spur_error_set: got %b exp 1", err[SPUR]); end
    nchecks++; if (td[SPUR] !== 32'd0) begin nerrs++; $display("FAIL spur_done_idle: got %0d exp 0", td[SPUR]); end
    nchecks++; if (mn[SPUR] !== ALL_ONES) begin nerrs++; $display("FAIL spur_min_idle: got %0h exp ffffffff", mn[SPUR]); end
    run_model(SPUR, 3, 1, 16, 0, 0);
    nchecks++; if (td[SPUR] !== 32'd2) begin nerrs++; $display("FAIL spur_done: got %0d exp 2", td[SPUR]); end
    nchecks++; if (ts[SPUR] !== 32'd2) begin nerrs++; $display("FAIL spur_started: got %0d exp 2", ts[SPUR]); end
    nchecks++; if (mn[SPUR] !== 32'd3) begin nerrs++; $display("FAIL spur_min: got %0d exp 3", mn[SPUR]); end
    nchecks++; if (mx[SPUR] !== 32'd3) begin nerrs++; $display("FAIL spur_max: got %0d exp 3", mx[SPUR]); end
    nchecks++; if (err[SPUR] !== 1'b1) begin nerrs++; $display("FAIL spur_error_sticky: got %b exp 1", err[SPUR]); end
    nchecks++; if (fin[SPUR] !== 1'b1) begin nerrs++; $display("FAIL spur_finish: got %b exp 1", fin[SPUR]); end
  endtask

  task automatic test_enable_gap_reset();
    do_reset();
    run_model(PIPE, 7, 99, 26, 3, 10);
    nchecks++; if (m_gap_acc != 0) begin nerrs++; $display("FAIL gap_accepts: got %0d exp 0", m_gap_acc); end
    nchecks++; if (m_td_gap_end !== 32'd3) begin nerrs++; $display("FAIL gap_done_during_gap: got %0d exp 3", m_td_gap_end); end
    nchecks++; if (ts[PIPE] !== 32'd8) begin nerrs++; $display("FAIL gap_started: got %0d exp 8", ts[PIPE]); end
    nchecks++; if (td[PIPE] !== 32'd7) begin nerrs++; $display("FAIL gap_done_drain: got %0d exp 7", td[PIPE]); end
    nchecks++; if (mx[PIPE] !== 32'd7) begin nerrs++; $display("FAIL gap_max: got %0d exp 7", mx[PIPE]); end
    nchecks++; if (fin[PIPE] !== 1'b0) begin nerrs++; $display("FAIL gap_finish_drain: got %b exp 0", fin[PIPE]); end
    #2 reset = 1'b0;
    #1;
    nchecks++; if (st[PIPE] !== 1'b0) begin nerrs++; $display("FAIL rst_ap_start: got %b exp 0", st[PIPE]); end
    nchecks++; if (ts[PIPE] !== 32'd0) begin nerrs++; $display("FAIL rst_started: got %0d exp 0", ts[PIPE]); end
    nchecks++; if (td[PIPE] !== 32'd0) begin nerrs++; $display("FAIL rst_done: got %0d exp 0", td[PIPE]); end
    nchecks++; if (ll[PIPE] !== 32'd0) begin nerrs++; $display("FAIL rst_last: got %0d exp 0", ll[PIPE]); end
    nchecks++; if (mn[PIPE] !== ALL_ONES) begin nerrs++; $display("FAIL rst_min: got %0h exp ffffffff", mn[PIPE]); end
    nchecks++; if (mx[PIPE] !== 32'd0) begin nerrs++; $display("FAIL rst_max: got %0d exp 0", mx[PIPE]); end
    nchecks++; if (fin[PIPE] !== 1'b0) begin nerrs++; $display("FAIL rst_finish: got %b exp 0", fin[PIPE]); end
    nchecks++; if (err[PIPE] !== 1'b0) begin nerrs++; $display("FAIL rst_error: got %b exp 0", err[PIPE]); end
  endtask

  task automatic test_zero();
    do_reset();
    en[ZERO] = 1'b1;
    tick();
    nchecks++; if (fin[ZERO] !== 1'b1) begin nerrs++; $display("FAIL zero_finish: got %b exp 1", fin[ZERO]); end
    nchecks++; if (st[ZERO] !== 1'b0) begin nerrs++; $display("FAIL zero_ap_start: got %b exp 0", st[ZERO]); end
    repeat (4) tick();
    nchecks++; if (st[ZERO] !== 1'b0) begin nerrs++; $display("FAIL zero_ap_start_later: got %b exp 0", st[ZERO]); end
    nchecks++; if (fin[ZERO] !== 1'b1) begin nerrs++; $display("FAIL zero_finish_sticky: got %b exp 1", fin[ZERO]); end
    nchecks++; if (ts[ZERO] !== 32'd0) begin nerrs++; $display("FAIL zero_started: got %0d exp 0", ts[ZERO]); end
    en[ZERO] = 1'b0;
  endtask

  initial begin
    en  = '0;
    rdy = '0;
    dn  = '0;
    test_reset();
    test_sequential();
    test_back_to_back();
    test_bypass();
    test_spurious();
    test_enable_gap_reset();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
